// File: rtl/vga_timing_controller.sv
// 640x480@60Hz VGA raster timing: pixel counters with phase FSMs, plus
// registered sync and blanked RGB pins that lag the x/y coordinates by one cycle.
module vga_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        CLOCK_25,
    input  logic        RESET,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        video_on,
    output logic        frame_start,
    output logic        line_start,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FRT_END = 12'(H_ACTIVE + H_FRONT - 1);
    localparam logic [11:0] H_SYN_END = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FRT_END = 12'(V_ACTIVE + V_FRONT - 1);
    localparam logic [11:0] V_SYN_END = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [11:0] h_r, v_r, h_next_s, v_next_s;
    phase_t      h_phase_r, v_phase_r, h_phase_next_s, v_phase_next_s;
    logic        h_wrap_s, video_on_s;
    logic        hs_r, vs_r;
    logic [2:0]  rgb_r;

    // Counter next values; the vertical counter only moves on the line wrap.
    always_comb begin
        h_wrap_s = (h_r == H_LAST);
        h_next_s = h_r;
        v_next_s = v_r;
        if (h_wrap_s) begin
            h_next_s = 12'd0;
            if (v_r == V_LAST) begin
                v_next_s = 12'd0;
            end else begin
                v_next_s = v_r + 12'd1;
            end
        end else begin
            h_next_s = h_r + 12'd1;
        end
    end

    // Phase transitions fire on the last count of each region, so the phase
    // register always names the region of the counter value it sits beside.
    always_comb begin
        h_phase_next_s = h_phase_r;
        case (h_phase_r)
            PH_ACTIVE: if (h_r == H_ACT_END) h_phase_next_s = PH_FRONT;  else h_phase_next_s = PH_ACTIVE;
            PH_FRONT:  if (h_r == H_FRT_END) h_phase_next_s = PH_SYNC;   else h_phase_next_s = PH_FRONT;
            PH_SYNC:   if (h_r == H_SYN_END) h_phase_next_s = PH_BACK;   else h_phase_next_s = PH_SYNC;
            PH_BACK:   if (h_wrap_s)         h_phase_next_s = PH_ACTIVE; else h_phase_next_s = PH_BACK;
            default:   h_phase_next_s = PH_BACK;
        endcase
    end

    // Vertical phase steps with the same structure, gated by the line wrap.
    always_comb begin
        v_phase_next_s = v_phase_r;
        if (h_wrap_s) begin
            case (v_phase_r)
                PH_ACTIVE: if (v_r == V_ACT_END) v_phase_next_s = PH_FRONT;  else v_phase_next_s = PH_ACTIVE;
                PH_FRONT:  if (v_r == V_FRT_END) v_phase_next_s = PH_SYNC;   else v_phase_next_s = PH_FRONT;
                PH_SYNC:   if (v_r == V_SYN_END) v_phase_next_s = PH_BACK;   else v_phase_next_s = PH_SYNC;
                PH_BACK:   if (v_r == V_LAST)    v_phase_next_s = PH_ACTIVE; else v_phase_next_s = PH_BACK;
                default:   v_phase_next_s = PH_BACK;
            endcase
        end else begin
            v_phase_next_s = v_phase_r;
        end
    end

    // Counter and phase state; reset parks on the last pixel so the first edge opens a frame.
    always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
            h_r       <= H_LAST;
            v_r       <= V_LAST;
            h_phase_r <= PH_BACK;
            v_phase_r <= PH_BACK;
        end else begin
            h_r       <= h_next_s;
            v_r       <= v_next_s;
            h_phase_r <= h_phase_next_s;
            v_phase_r <= v_phase_next_s;
        end
    end

    assign video_on_s = (h_phase_r == PH_ACTIVE) && (v_phase_r == PH_ACTIVE);

    // Display pins, one cycle behind x/y; color is blanked outside the active area.
    always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
            rgb_r <= 3'b000;
        end else begin
            hs_r <= (h_phase_r != PH_SYNC);
            vs_r <= (v_phase_r != PH_SYNC);
            if (video_on_s) begin
                rgb_r <= color;
            end else begin
                rgb_r <= 3'b000;
            end
        end
    end

    assign x           = h_r;
    assign y           = v_r;
    assign video_on    = video_on_s;
    assign line_start  = (h_r == 12'd0);
    assign frame_start = (h_r == 12'd0) && (v_r == 12'd0);
    assign VGA_HS      = hs_r;
    assign VGA_VS      = vs_r;
    assign VGA_R       = rgb_r[2];
    assign VGA_G       = rgb_r[1];
    assign VGA_B       = rgb_r[0];

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: full-size instance for line/pixel behaviour, shrunken instance
// so whole frames (vertical sync, frame period) fit in a short run.
module tb_vga_timing_controller;

    localparam int S_HT = 30;
    localparam int S_VT = 15;

    logic        clk;
    logic        rst_a, rst_b;
    logic [2:0]  color_a, color_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    logic        von_a, fs_a, ls_a, hs_a, vs_a, r_a, g_a, b_a;
    logic        von_b, fs_b, ls_b, hs_b, vs_b, r_b, g_b, b_b;

    int checks, errors;
    int mh_a, mv_a, mh_b, mv_b;
    int ph_a, pv_a, ph_b, pv_b;
    logic prst_a, prst_b;
    logic [2:0] pcol_a, pcol_b;

    vga_timing_controller dut_a (
        .CLOCK_25(clk), .RESET(rst_a), .color(color_a), .x(x_a), .y(y_a),
        .video_on(von_a), .frame_start(fs_a), .line_start(ls_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
    );

    vga_timing_controller #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .CLOCK_25(clk), .RESET(rst_b), .color(color_b), .x(x_b), .y(y_b),
        .video_on(von_b), .frame_start(fs_b), .line_start(ls_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [1:0] phase_of(int val, int act, int frt, int syn);
        if (val < act) return 2'd0;
        else if (val < act + frt) return 2'd1;
        else if (val < act + frt + syn) return 2'd2;
        else return 2'd3;
    endfunction

    // One clock: capture pre-edge model state, advance both models, land on the falling edge.
    task automatic tick();
        @(posedge clk);
        ph_a = mh_a; pv_a = mv_a; prst_a = rst_a; pcol_a = color_a;
        ph_b = mh_b; pv_b = mv_b; prst_b = rst_b; pcol_b = color_b;
        if (rst_a) begin mh_a = 799; mv_a = 524; end
        else if (mh_a == 799) begin mh_a = 0; mv_a = (mv_a == 524) ? 0 : mv_a + 1; end
        else mh_a = mh_a + 1;
        if (rst_b) begin mh_b = S_HT - 1; mv_b = S_VT - 1; end
        else if (mh_b == S_HT - 1) begin mh_b = 0; mv_b = (mv_b == S_VT - 1) ? 0 : mv_b + 1; end
        else mh_b = mh_b + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        checks++; if (x_a !== 12'd799 || y_a !== 12'd524) begin errors++; $display("FAIL reset_xy: x=%0d y=%0d required 799 524", x_a, y_a); end
        checks++; if ({von_a, fs_a, ls_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: %b required 000", {von_a, fs_a, ls_a}); end
        checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL reset_sync: %b required 11", {hs_a, vs_a}); end
        checks++; if ({r_a, g_a, b_a} !== 3'b000) begin errors++; $display("FAIL reset_rgb: %b required 000", {r_a, g_a, b_a}); end
        checks++; if (x_b !== 12'd29 || y_b !== 12'd14) begin errors++; $display("FAIL reset_xy_small: x=%0d y=%0d required 29 14", x_b, y_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin errors++; $display("FAIL release_xy: x=%0d y=%0d required 0 0", x_a, y_a); end
        checks++; if ({fs_a, von_a, ls_a} !== 3'b111) begin errors++; $display("FAIL release_flags: %b required 111", {fs_a, von_a, ls_a}); end
        checks++; if (x_b !== 12'd0 || y_b !== 12'd0 || fs_b !== 1'b1) begin errors++; $display("FAIL release_small: x=%0d y=%0d fs=%b required 0 0 1", x_b, y_b, fs_b); end
        tick();
        checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL release_sync: %b required 11", {hs_a, vs_a}); end
        checks++; if (x_a !== 12'd1 || fs_a !== 1'b0) begin errors++; $display("FAIL second_cycle: x=%0d fs=%b required 1 0", x_a, fs_a); end
    endtask

    task automatic test_line();
        int last_ls, n_ls, run, n_runs, prev_x;
        logic prev_hs, exp_hs, exp_vs;
        logic [1:0] hp, vp;
        last_ls = -1; n_ls = 0; run = 0; n_runs = 0;
        prev_x = int'(x_a); prev_hs = hs_a;
        for (int c = 0; c < 1700; c++) begin
            tick();
            exp_hs = prst_a || !(ph_a >= 656 && ph_a < 752);
            exp_vs = prst_a || !(pv_a >= 490 && pv_a < 492);
            hp = dut_a.h_phase_r;
            vp = dut_a.v_phase_r;
            checks++; if (x_a !== 12'(mh_a) || y_a !== 12'(mv_a)) begin errors++; $display("FAIL line_xy: x=%0d y=%0d required %0d %0d", x_a, y_a, mh_a, mv_a); end
            checks++; if (hs_a !== exp_hs || vs_a !== exp_vs) begin errors++; $display("FAIL line_sync at x=%0d: hs=%b vs=%b required %b %b", x_a, hs_a, vs_a, exp_hs, exp_vs); end
            checks++; if (hp !== phase_of(mh_a, 640, 16, 96) || vp !== phase_of(mv_a, 480, 10, 2)) begin errors++; $display("FAIL line_phase at x=%0d: h=%0d v=%0d required %0d %0d", x_a, hp, vp, phase_of(mh_a, 640, 16, 96), phase_of(mv_a, 480, 10, 2)); end
            checks++; if (von_a !== (mh_a < 640 && mv_a < 480) || ls_a !== (mh_a == 0)) begin errors++; $display("FAIL line_von_ls at x=%0d: von=%b ls=%b required %b %b", x_a, von_a, ls_a, (mh_a < 640 && mv_a < 480), (mh_a == 0)); end
            if (ls_a) begin
                if (last_ls >= 0) begin
                    checks++; if (c - last_ls != 800) begin errors++; $display("FAIL line_period: %0d required 800", c - last_ls); end
                end
                last_ls = c; n_ls++;
            end
            if (!hs_a && prev_hs) begin
                checks++; if (prev_x != 656) begin errors++; $display("FAIL hs_start: previous x=%0d required 656", prev_x); end
            end
            if (!hs_a) run++;
            else if (run > 0) begin
                checks++; if (run != 96) begin errors++; $display("FAIL hs_width: %0d required 96", run); end
                n_runs++; run = 0;
            end
            prev_hs = hs_a; prev_x = int'(x_a);
        end
        checks++; if (n_ls != 2) begin errors++; $display("FAIL line_count: %0d required 2", n_ls); end
        checks++; if (n_runs != 2) begin errors++; $display("FAIL hs_count: %0d required 2", n_runs); end
    endtask

    task automatic test_color();
        int guard;
        color_a = 3'b000; guard = 0;
        while (!(mh_a == 10 && mv_a == 5) && guard < 5000) begin tick(); guard++; end
        checks++; if (x_a !== 12'd10 || y_a !== 12'd5) begin errors++; $display("FAIL color_pos: x=%0d y=%0d required 10 5", x_a, y_a); end
        color_a = 3'b101; tick();
        checks++; if ({r_a, g_a, b_a} !== 3'b101) begin errors++; $display("FAIL rgb_101: %b required 101", {r_a, g_a, b_a}); end
        color_a = 3'b010; tick();
        checks++; if ({r_a, g_a, b_a} !== 3'b010) begin errors++; $display("FAIL rgb_010: %b required 010", {r_a, g_a, b_a}); end
        guard = 0;
        while (mh_a != 639 && guard < 1000) begin tick(); guard++; end
        color_a = 3'b111; tick();
        checks++; if ({r_a, g_a, b_a} !== 3'b111) begin errors++; $display("FAIL rgb_last_active: %b required 111", {r_a, g_a, b_a}); end
        tick();
        checks++; if ({r_a, g_a, b_a} !== 3'b000) begin errors++; $display("FAIL rgb_first_blank: %b required 000", {r_a, g_a, b_a}); end
        guard = 0;
        while (mh_a != 700 && guard < 1000) begin tick(); guard++; end
        tick();
        checks++; if ({r_a, g_a, b_a} !== 3'b000 || x_a !== 12'd701) begin errors++; $display("FAIL rgb_x700: rgb=%b x=%0d required 000 701", {r_a, g_a, b_a}, x_a); end
    endtask

    task automatic test_async_reset();
        int guard;
        color_a = 3'b111; guard = 0;
        while (!(mh_a == 300 && mv_a == 6) && guard < 2000) begin tick(); guard++; end
        checks++; if (x_a !== 12'd300 || y_a !== 12'd6 || {r_a, g_a, b_a} !== 3'b111) begin errors++; $display("FAIL pre_reset: x=%0d y=%0d rgb=%b required 300 6 111", x_a, y_a, {r_a, g_a, b_a}); end
        #5 rst_a = 1'b1; mh_a = 799; mv_a = 524;
        #1;
        checks++; if (x_a !== 12'd799 || y_a !== 12'd524) begin errors++; $display("FAIL async_xy: x=%0d y=%0d required 799 524", x_a, y_a); end
        checks++; if ({hs_a, vs_a, r_a, g_a, b_a} !== 5'b11000) begin errors++; $display("FAIL async_pins: %b required 11000", {hs_a, vs_a, r_a, g_a, b_a}); end
        checks++; if ({von_a, fs_a, ls_a} !== 3'b000) begin errors++; $display("FAIL async_flags: %b required 000", {von_a, fs_a, ls_a}); end
        tick();
        checks++; if (x_a !== 12'd799 || y_a !== 12'd524) begin errors++; $display("FAIL reset_hold: x=%0d y=%0d required 799 524", x_a, y_a); end
        rst_a = 1'b0; tick();
        checks++; if (x_a !== 12'd0 || y_a !== 12'd0 || fs_a !== 1'b1) begin errors++; $display("FAIL async_release: x=%0d y=%0d fs=%b required 0 0 1", x_a, y_a, fs_a); end
        guard = 0;
        while (mh_a != 700 && guard < 1000) begin tick(); guard++; end
        checks++; if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_in_sync: %b required 0", hs_a); end
        #5 rst_a = 1'b1; mh_a = 799; mv_a = 524;
        #1;
        checks++; if (hs_a !== 1'b1 || x_a !== 12'd799) begin errors++; $display("FAIL async_hs: hs=%b x=%0d required 1 799", hs_a, x_a); end
        tick();
        rst_a = 1'b0; tick();
        checks++; if (fs_a !== 1'b1 || von_a !== 1'b1) begin errors++; $display("FAIL async_release2: fs=%b von=%b required 1 1", fs_a, von_a); end
        color_a = 3'b000;
    endtask

    task automatic test_frame_small();
        int guard, last_fs, n_fs, run, n_runs, prev_x, prev_y;
        logic prev_vs, exp_hs, exp_vs;
        logic [2:0] exp_rgb;
        logic [1:0] hp, vp;
        guard = 0;
        while (!(mh_b == 0 && mv_b == 0) && guard < 1000) begin tick(); guard++; end
        checks++; if (x_b !== 12'd0 || y_b !== 12'd0 || fs_b !== 1'b1) begin errors++; $display("FAIL small_seek: x=%0d y=%0d fs=%b required 0 0 1", x_b, y_b, fs_b); end
        last_fs = -1; n_fs = 0; run = 0; n_runs = 0;
        prev_x = int'(x_b); prev_y = int'(y_b); prev_vs = vs_b;
        for (int c = 0; c < 3 * S_HT * S_VT; c++) begin
            color_b = 3'(c);
            tick();
            exp_hs = prst_b || !(ph_b >= 20 && ph_b < 26);
            exp_vs = prst_b || !(pv_b >= 10 && pv_b < 12);
            exp_rgb = (!prst_b && ph_b < 16 && pv_b < 8) ? pcol_b : 3'b000;
            hp = dut_b.h_phase_r;
            vp = dut_b.v_phase_r;
            checks++; if (x_b !== 12'(mh_b) || y_b !== 12'(mv_b)) begin errors++; $display("FAIL small_xy: x=%0d y=%0d required %0d %0d", x_b, y_b, mh_b, mv_b); end
            checks++; if (hp !== phase_of(mh_b, 16, 4, 6) || vp !== phase_of(mv_b, 8, 2, 2)) begin errors++; $display("FAIL small_phase at %0d,%0d: h=%0d v=%0d required %0d %0d", x_b, y_b, hp, vp, phase_of(mh_b, 16, 4, 6), phase_of(mv_b, 8, 2, 2)); end
            checks++; if (von_b !== (mh_b < 16 && mv_b < 8) || fs_b !== (mh_b == 0 && mv_b == 0)) begin errors++; $display("FAIL small_flags at %0d,%0d: von=%b fs=%b", x_b, y_b, von_b, fs_b); end
            checks++; if (hs_b !== exp_hs || vs_b !== exp_vs) begin errors++; $display("FAIL small_sync at %0d,%0d: hs=%b vs=%b required %b %b", x_b, y_b, hs_b, vs_b, exp_hs, exp_vs); end
            checks++; if ({r_b, g_b, b_b} !== exp_rgb) begin errors++; $display("FAIL small_rgb at %0d,%0d: %b required %b", x_b, y_b, {r_b, g_b, b_b}, exp_rgb); end
            if (fs_b) begin
                if (last_fs >= 0) begin
                    checks++; if (c - last_fs != S_HT * S_VT) begin errors++; $display("FAIL frame_period: %0d required %0d", c - last_fs, S_HT * S_VT); end
                end
                last_fs = c; n_fs++;
            end
            if (!vs_b && prev_vs) begin
                checks++; if (prev_x != 0 || prev_y != 10) begin errors++; $display("FAIL vs_start: previous %0d,%0d required 0,10", prev_x, prev_y); end
            end
            if (!vs_b) run++;
            else if (run > 0) begin
                checks++; if (run != 2 * S_HT) begin errors++; $display("FAIL vs_width: %0d required %0d", run, 2 * S_HT); end
                n_runs++; run = 0;
            end
            prev_vs = vs_b; prev_x = int'(x_b); prev_y = int'(y_b);
        end
        checks++; if (n_fs != 3 || n_runs != 3) begin errors++; $display("FAIL frame_counts: frames=%0d vs_pulses=%0d required 3 3", n_fs, n_runs); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        color_a = 3'b000; color_b = 3'b000;
        mh_a = 799; mv_a = 524; mh_b = S_HT - 1; mv_b = S_VT - 1;
        ph_a = 799; pv_a = 524; ph_b = S_HT - 1; pv_b = S_VT - 1;
        prst_a = 1'b1; prst_b = 1'b1; pcol_a = 3'b000; pcol_b = 3'b000;
        test_reset();
        test_line();
        test_color();
        test_async_reset();
        test_frame_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
